// File: rtl/mb_add_pkg.sv
// Shared types and constants for the multi-byte sequential adder.
package mb_add_pkg;
    localparam int BYTE_W        = 8;
    localparam int MAX_BYTES_DEF = 4;

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_t;
endpackage

// File: rtl/mb_add_seq_byte_adder.sv
// Combinational 8-bit ripple-carry adder used for one byte of the carry chain.
module byte_adder
    import mb_add_pkg::*;
(
    input  logic              cin,
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    output logic              cout,
    output logic [BYTE_W-1:0] s
);
    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/mb_add_seq.sv
// Byte-serial multi-byte adder (LSB first) with valid/ready on both sides.
// Optional subtract mode is enabled by defining MB_ADD_SEQ_SUB_EN.
module mb_add_seq
    import mb_add_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_err
`ifdef MB_ADD_SEQ_SUB_EN
    ,
    input  logic              op_sub
`endif
);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    state_t            state_q, state_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_sum_q, out_sum_d;
    logic              out_last_q, out_last_d;
    logic              out_cout_q, out_cout_d;
    logic              out_err_q, out_err_d;

    logic              xfer_in, final_byte, sub_eff, cin, co;
    logic [BYTE_W-1:0] b_eff, sum;

`ifdef MB_ADD_SEQ_SUB_EN
    logic sub_q, sub_d;
    // op_sub is only looked at on the first byte; later bytes use the held copy.
    assign sub_eff = (state_q == FIRST) ? op_sub : sub_q;
    assign sub_d   = (xfer_in && state_q == FIRST) ? op_sub : sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else        sub_q <= sub_d;
    end
`else
    assign sub_eff = 1'b0;
`endif

    assign in_ready   = !out_valid_q || out_ready;
    assign xfer_in    = in_valid && in_ready;
    assign final_byte = in_last || (cnt_q == CNT_W'(MAX_BYTES - 1));
    // Initial carry equals sub_eff: 0 for add, 1 for two's-complement subtract.
    assign cin        = (state_q == FIRST) ? sub_eff : carry_q;
    assign b_eff      = sub_eff ? ~in_b : in_b;

    byte_adder u_add (
        .cin  (cin),
        .a    (in_a),
        .b    (b_eff),
        .cout (co),
        .s    (sum)
    );

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_err_d   = out_err_q;
        if (xfer_in) begin
            state_d     = final_byte ? FIRST : MID;
            carry_d     = final_byte ? 1'b0 : co;
            cnt_d       = final_byte ? '0 : cnt_q + 1'b1;
            out_valid_d = 1'b1;
            out_sum_d   = sum;
            out_last_d  = final_byte;
            out_cout_d  = final_byte & co;
            out_err_d   = final_byte & !in_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FIRST;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_err   = out_err_q;
endmodule

// File: tb/tb_mb_add_seq.sv
// Bench for mb_add_seq: directed vectors plus random traffic against a whole-operand model.
module tb_mb_add_seq;
    localparam int MAXB = 4;

    logic       clk, rst_n;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_a, in_b;
    logic       out_valid, out_ready, out_last, out_cout, out_err;
    logic [7:0] out_sum;
    logic       op_sub;

    int n_cmp = 0;
    int n_err = 0;

    mb_add_seq #(.MAX_BYTES(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_err   (out_err)
`ifdef MB_ADD_SEQ_SUB_EN
        ,
        .op_sub    (op_sub)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference: operands accumulate as wide integers; each output byte is
    // the corresponding byte of (A + B + cin) over the bytes seen so far.
    logic [135:0] ma, mb;
    int           mn = 0;
    logic         msub = 1'b0;
    logic [10:0]  expq[$];

    task automatic model_push(input logic [7:0] a, input logic [7:0] b,
                              input logic l, input logic s);
        logic [135:0] mask, bb, tot;
        logic         fin;
        if (mn == 0) begin
            msub = s;
            ma   = '0;
            mb   = '0;
        end
        ma[8*mn +: 8] = a;
        mb[8*mn +: 8] = b;
        mn++;
        fin  = l || (mn == MAXB);
        mask = (136'd1 << (8*mn)) - 136'd1;
        bb   = msub ? (~mb & mask) : mb;
        tot  = ma + bb + {135'd0, msub};
        expq.push_back({tot[8*(mn-1) +: 8], fin, fin & tot[8*mn], fin & !l});
        if (fin) mn = 0;
    endtask

    task automatic mon();
        logic s;
`ifdef MB_ADD_SEQ_SUB_EN
        s = op_sub;
`else
        s = 1'b0;
`endif
        chk("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
        if (out_valid) begin
            chk("exp_avail", {31'd0, expq.size() > 0}, 32'd1);
            if (expq.size() > 0) begin
                chk("out_byte", {21'd0, out_sum, out_last, out_cout, out_err}, {21'd0, expq[0]});
                if (out_ready) void'(expq.pop_front());
            end
        end
        if (in_valid && in_ready) model_push(in_a, in_b, in_last, s);
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic l, input logic r);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic [7:0] s, input logic l,
                           input logic c, input logic e);
        chk(tag, {20'd0, out_valid, out_sum, out_last, out_cout, out_err}, {20'd0, 1'b1, s, l, c, e});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && expq.size() > 0; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("drained", expq.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        out_ready = 1'b0; op_sub = 1'b0;
        @(posedge clk); #1;
        chk("rst_state", {20'd0, out_valid, out_sum, out_last, out_cout, out_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 0x01FF + 0x0001
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1); exp_out("add2_b0", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h01, 8'h00, 1'b1, 1'b1); exp_out("add2_b1", 8'h02, 1'b1, 1'b0, 1'b0);

        // 0xFFFFFFFF + 1
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1); exp_out("add4_b0", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1); exp_out("add4_b3", 8'h00, 1'b1, 1'b1, 1'b0);

        // five bytes, no in_last: truncation at MAX_BYTES, then a fresh carry
        step(1'b1, 8'h80, 8'h80, 1'b0, 1'b1); exp_out("trunc_b0", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
        step(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
        step(1'b1, 8'h80, 8'h80, 1'b0, 1'b1); exp_out("trunc_b3", 8'h01, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h80, 8'h80, 1'b0, 1'b1); exp_out("trunc_new", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 8'h00, 1'b1, 1'b1); exp_out("trunc_end", 8'h01, 1'b1, 1'b0, 1'b0);
        drain();

        // backpressure then full throughput
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            exp_out("bp_hold", 8'h33, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 8'h01, 8'h01, 1'b0, 1'b1); exp_out("bp_tp0", 8'h02, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 8'h02, 1'b1, 1'b1); exp_out("bp_tp1", 8'h04, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("drain_clr", {31'd0, out_valid}, 32'd0);

        // reset after byte 1 of 3
        step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1); exp_out("rst_b0", 8'hFE, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_async", {23'd0, out_valid, out_sum}, 32'd0);
        expq.delete();
        mn = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 8'h01, 8'h01, 1'b1, 1'b1); exp_out("rst_first", 8'h02, 1'b1, 1'b0, 1'b0);
        drain();

`ifdef MB_ADD_SEQ_SUB_EN
        // 0x0100 - 0x0001
        op_sub = 1'b1;
        step(1'b1, 8'h00, 8'h01, 1'b0, 1'b1); exp_out("sub_b0", 8'hFF, 1'b0, 1'b0, 1'b0);
        op_sub = 1'b0;
        step(1'b1, 8'h01, 8'h00, 1'b1, 1'b1); exp_out("sub_b1", 8'h00, 1'b1, 1'b1, 1'b0);
        drain();
`endif

        for (int i = 0; i < 800; i++) begin
            op_sub = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 7));
        end
        drain();
        chk("end_idle", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mb_add_seq.md
MB_ADD_SEQ -- requirements
Module: mb_add_seq

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, meaning the maximum operand length in bytes (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand byte pair is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a byte pair this cycle.
REQ-006 SHALL have ports in_a and in_b, input, 8 bits each: operand bytes, least-significant byte first.
REQ-007 SHALL have port in_last, input, 1 bit: the current byte is the most-significant byte of the operand.
REQ-008 SHALL have port out_valid, output, 1 bit: a sum byte is held.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the sum byte.
REQ-010 SHALL have port out_sum, output, 8 bits: the sum byte.
REQ-011 SHALL have port out_last, output, 1 bit: the sum byte is the final byte of the operation.
REQ-012 SHALL have port out_cout, output, 1 bit: the final carry, meaningful only when out_last=1.
REQ-013 SHALL have port out_err, output, 1 bit: the operation was truncated at MAX_BYTES, meaningful only when out_last=1.

Function
REQ-014 SHALL transfer an input byte only when in_valid and in_ready are both 1 in the same cycle, and an output byte only when out_valid and out_ready are both 1.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally; in_ready SHALL not depend on in_valid.
REQ-016 SHALL register out_sum = (in_a + in_b + carry_q)[7:0] on each input transfer, with out_valid rising on the next clock edge (latency 1 cycle).
REQ-017 SHALL update carry_q on each non-final input transfer to bit 8 of that addition.
REQ-018 SHALL implement a two-state FSM: FIRST (carry_q forced to the initial carry, byte count 0) and MID (carry chain active).
REQ-019 SHALL move FIRST->MID on a transfer with in_last=0, stay in MID on further non-final transfers, and go to FIRST on a final transfer.
REQ-020 SHALL treat a transfer as final when in_last=1 or when it is byte number MAX_BYTES; if final by count with in_last=0, SHALL set out_err=1 with that byte.
REQ-021 SHALL set out_cout to bit 8 of the final addition and out_last=1 on the final byte, and hold out_last, out_cout and out_err at 0 on all other bytes.
REQ-022 SHALL keep out_sum, out_last, out_cout and out_err stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on simultaneous output drain and input transfer, load the new byte and keep out_valid=1 with no bubble.
REQ-024 SHALL clear out_valid when a drain occurs without an input transfer.
REQ-025 SHALL accept a single-byte operation (in_last=1 on the first byte) with carry-in equal to the initial carry.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-operation, set the state to FIRST, carry_q=0, byte count=0, out_valid=0, out_sum=0x00, and out_last=out_cout=out_err=0.
REQ-027 SHALL discard any partial operation on reset and SHALL NOT emit its remaining bytes.

Configuration
REQ-028 SHALL support macro MB_ADD_SEQ_SUB_EN.
REQ-029 SHALL, when MB_ADD_SEQ_SUB_EN is defined, add port op_sub (input, 1 bit), sampled on the first byte and held for the whole operation; when the held value is 1, SHALL add ~in_b with initial carry 1, so out_cout=1 means no borrow.
REQ-030 SHALL, when MB_ADD_SEQ_SUB_EN is not defined, have no op_sub port, SHALL always add, and SHALL use initial carry 0.

Structure
REQ-031 SHALL take BYTE_W=8, the FSM state enum (FIRST, MID) and the MAX_BYTES default from shared package mb_add_pkg.
REQ-032 SHALL instantiate one combinational sub-module, byte_adder (8-bit ripple-carry, ports cin, a, b, cout, s), with all registers in mb_add_seq.

Verification
REQ-033 SHALL cover a 2-byte add, A=0x01FF and B=0x0001, out_ready=1 -> bytes 0x00 (out_last=0) then 0x02 (out_last=1, out_cout=0).
REQ-034 SHALL cover a 4-byte add, 0xFFFFFFFF+0x00000001 -> 0x00,0x00,0x00,0x00, out_cout=1, out_err=0.
REQ-035 SHALL cover MAX_BYTES=4 with 5 bytes and no in_last -> the 4th byte carries out_last=1 and out_err=1, and the 5th byte starts a new operation with carry 0.
REQ-036 SHALL cover backpressure, out_ready=0 for 3 cycles -> in_ready=0, out_sum held, no byte lost, and full throughput of one byte per cycle once out_ready=1.
REQ-037 SHALL cover rst_n pulsed low after byte 1 of 3 -> out_valid=0 immediately and the next byte is treated as FIRST.
REQ-038 SHALL cover, with MB_ADD_SEQ_SUB_EN, 0x0100-0x0001 -> bytes 0xFF then 0x00, out_cout=1.
